fifo_packer: RTL and testbench
==============================

Name: fifo_packer

Overview:
- Write-side counterpart of the line-FIFO read adapter.
- Accepts variable-size writes (16- or 32-bit) and packs them little-endian into 128-bit lines.
- Pushes each completed line into a downstream 128-bit FIFO.
- Sits between narrow producers (trace/debug/DMA-to-memory streams) and wide line FIFOs.

Parameters:
- NUM_LINES, 2, line buffers (power of 2, ≥2).
- LINE_BYTES, 16, bytes per line; fixed to 16, since the line width is 128.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- we_i  in  1  write strobe, valid when ~full_o
- wsize_i  in  1  0 -> 16-bit (wdata_i[15:0]), 1 -> 32-bit
- wdata_i  in  32  write data
- full_o  out  1  write not accepted this cycle
- idle_o  out  1  no buffered bytes, no pending push
- fifo_full_i  in  1  downstream FIFO full
- fifo_we_o  out  1  downstream push strobe
- fifo_wdata_o  out  128  downstream push data
- flush_i  in  1  commit partial line (only with FIFO_PACKER_FLUSH_EN)

Behaviour:
- Reset: synchronous, active-high. All lines cleared to 0; fill_ptr=drain_ptr=0; bytes_used=0; state=IDLE; fifo_we_o=0; full_o=0; idle_o=1.
- Pointers: fill_ptr and drain_ptr are each log2(NUM_LINES)+1 bits, with a wrap bit. count = fill_ptr - drain_ptr (committed lines). Line index = ptr[low bits].
- Active fill line: lines[fill_ptr]. It is writable only while count < NUM_LINES.
- bytes_used: 0..14 in steps of 2, always even.
- full_o is combinational from state only, never from we_i/wsize_i:
  - full_o = (count==NUM_LINES) | (count==NUM_LINES-1 & bytes_used==14) | flush_pend.
  - Conservative: asserted even if the next write would be 16-bit.
- Accepted write (we_i & ~full_o), n = wsize_i ? 4 : 2 bytes:
  - Bytes are placed at byte offset bytes_used, low byte first.
  - If bytes_used+n < 16: bytes_used += n.
  - If bytes_used+n == 16: the line is committed (fill_ptr++) and bytes_used=0.
  - Straddle (32-bit with bytes_used==14): wdata_i[15:0] completes the current line, which commits. wdata_i[31:16] goes to byte 0..1 of the next line; bytes_used=2.
  - we_i while full_o: ignored, no state change.
- Drain FSM:
  - IDLE: if count>0, go to PUSH.
  - PUSH: fifo_we_o = ~fifo_full_i (combinational); fifo_wdata_o = lines[drain_ptr].
    - When fifo_we_o: that line is cleared to 0, drain_ptr++, next=IDLE.
    - Otherwise hold in PUSH.
  - Throughput is 1 line per 2 cycles; a producer needs ≥4 cycles per line.
- Latency: the edge that commits line L starts cycle N+1 with count>0 (IDLE -> PUSH). fifo_we_o can first assert in cycle N+2.
- Simultaneous commit (fill_ptr++) and drain (drain_ptr++) in one cycle: both apply; count unchanged.
- A committed line is never written; the fill side only touches lines[fill_ptr] while count<NUM_LINES.
- idle_o = (count==0) & (bytes_used==0) & (state==IDLE) & ~flush_pend.
- Reset mid-operation: all buffered data is discarded; no fifo_we_o in the cycle after reset asserts.

Optional Feature:
- Macro: FIFO_PACKER_FLUSH_EN.
- With the macro:
  - flush_i is present and sets flush_pend if bytes_used≠0 after that cycle's write.
  - A write in the same cycle is applied first. If the write straddles, the spill line is the one flushed.
  - While flush_pend & count<NUM_LINES: the partial line commits with zero upper bytes (fill_ptr++, bytes_used=0) and flush_pend clears.
  - flush_i with bytes_used==0 and no write is a no-op.
- Without the macro: no flush_i port; flush_pend is tied 0; partial lines wait until filled.

Decomposition:
- Package fifo_pkg:
  - LINE_BYTES constant.
  - wsize_t enum: SZ16=0, SZ32=1.
  - drain_state_t enum: IDLE, PUSH.
- Sub-module line_merge: combinational byte-enable insertion of up to 4 bytes at an even offset. It produces the current-line update and the spill half.

Test Plan:
- 8x 32-bit writes 0x03020100, 0x07060504 ... 0x1F1E1D1C -> two pushes: 0x0F0E...0100 then 0x1F1E...1110; idle_o=1 after.
- 7x 16-bit writes then 1x 32-bit 0xBBBBAAAA -> line 1 upper half-word 0xAAAA and pushed; bytes_used=2, next line byte0..1=0xBBBB.
- Hold fifo_full_i=1, write 32x 32-bit -> full_o asserts once 2 lines are committed; no fifo_we_o; release -> exactly 2 pushes, data intact and in order.
- bytes_used==14, count==1 -> full_o=1 even with wsize_i=0; we_i ignored.
- (FIFO_PACKER_FLUSH_EN) 3x 16-bit 0x1111, 0x2222, 0x3333 then flush_i -> push 0x...0000_333322221111 with upper 10 bytes zero.
- Reset asserted with 1 committed line plus a partial line -> no push afterwards; idle_o=1, full_o=0 the cycle after reset deasserts.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the line packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic {
        SZ16 = 1'b0,
        SZ32 = 1'b1
    } wsize_t;

    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } drain_state_t;

    // Number of bytes carried by one write of the given size.
    function automatic logic [4:0] wsize_bytes(input wsize_t sz);
        return (sz == SZ32) ? 5'd4 : 5'd2;
    endfunction

endpackage

// File: rtl/fifo_packer_line_merge.sv
// Inserts a 2- or 4-byte write at an even byte offset of a line; bytes past the top spill.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the merged line is written back.
module line_merge
    import fifo_pkg::*;
(
    input  logic [LINE_W-1:0] cur_line,
    input  logic [3:0]        offset,
    input  wsize_t            wsize,
    input  logic [31:0]       wdata,
    output logic [LINE_W-1:0] merged_line,
    output logic              spill_vld,
    output logic [15:0]       spill_dat
);

    logic [4:0] nbytes;
    logic [4:0] pos;

    assign nbytes = wsize_bytes(wsize);

    // Overlay the write bytes low-first starting at offset; anything past byte 15 is dropped here
    always_comb begin
        merged_line = cur_line;
        pos         = '0;
        for (int k = 0; k < 4; k++) begin
            if (5'(k) < nbytes) begin
                pos = {1'b0, offset} + 5'(k);
                if (pos < 5'(LINE_BYTES)) begin
                    merged_line[{pos[3:0], 3'b000} +: 8] = wdata[k*8 +: 8];
                end
            end
        end
    end

    // Only a 32-bit write landing on the last half-word crosses into the next line.
    assign spill_vld = (wsize == SZ32) && (offset == 4'd14);
    assign spill_dat = wdata[31:16];

endmodule

// File: rtl/fifo_packer.sv
// Packs 16/32-bit writes little-endian into 128-bit lines and pushes full lines downstream.
// Latency: line committed at edge N is pushed no earlier than cycle N+2; one push per 2 cycles.
// Backpressure: full_o from buffer state only; fifo_full_i holds the drain. FIFO_PACKER_FLUSH_EN adds flush_i.
module fifo_packer #(
    parameter int NUM_LINES  = 2,
    parameter int LINE_BYTES = 16
)(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic         wsize_i,
    input  logic [31:0]  wdata_i,
    output logic         full_o,
    output logic         idle_o,
    input  logic         fifo_full_i,
    output logic         fifo_we_o,
    output logic [127:0] fifo_wdata_o
`ifdef FIFO_PACKER_FLUSH_EN
    ,
    input  logic         flush_i
`endif
);

    import fifo_pkg::*;

    localparam int AW = $clog2(NUM_LINES);
    localparam int PW = AW + 1;
    localparam int LW = LINE_BYTES * 8;

    logic [LW-1:0]  lines [NUM_LINES];
    logic [PW-1:0]  fill_ptr;
    logic [PW-1:0]  drain_ptr;
    logic [PW-1:0]  count;
    logic [AW-1:0]  fill_idx;
    logic [AW-1:0]  fill_nxt_idx;
    logic [AW-1:0]  drain_idx;
    logic [3:0]     bytes_used;
    logic [3:0]     bytes_n;
    logic [4:0]     sum;
    wsize_t         wsize_e;
    logic           accept;
    logic           commit_w;
    logic           flush_commit;
    logic           drain_fire;
    logic [LW-1:0]  merged_line;
    logic           spill_vld;
    logic [15:0]    spill_dat;
    drain_state_t   state;
    drain_state_t   state_n;

    assign count        = fill_ptr - drain_ptr;
    assign fill_idx     = fill_ptr[AW-1:0];
    assign fill_nxt_idx = fill_idx + 1'b1;
    assign drain_idx    = drain_ptr[AW-1:0];
    assign wsize_e      = wsize_t'(wsize_i);

`ifdef FIFO_PACKER_FLUSH_EN
    logic flush_pend;

    // Remember a flush until the partial line left after this cycle's write can commit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_pend <= 1'b0;
        end else if (flush_i && (bytes_n != 4'd0)) begin
            flush_pend <= 1'b1;
        end else if (flush_commit) begin
            flush_pend <= 1'b0;
        end
    end
`else
    logic flush_pend;
    assign flush_pend = 1'b0;
`endif

    // Conservative: a straddling write needs two free lines, so block at 14 bytes with one slot left.
    assign full_o = (count == PW'(NUM_LINES))
                  | ((count == PW'(NUM_LINES - 1)) & (bytes_used == 4'd14))
                  | flush_pend;

    assign idle_o = (count == '0) & (bytes_used == 4'd0) & (state == IDLE) & ~flush_pend;

    assign accept       = we_i & ~full_o;
    assign sum          = {1'b0, bytes_used} + wsize_bytes(wsize_e);
    assign commit_w     = accept & (sum >= 5'(LINE_BYTES));
    assign flush_commit = flush_pend & (count < PW'(NUM_LINES));

    line_merge u_merge (
        .cur_line    (lines[fill_idx]),
        .offset      (bytes_used),
        .wsize       (wsize_e),
        .wdata       (wdata_i),
        .merged_line (merged_line),
        .spill_vld   (spill_vld),
        .spill_dat   (spill_dat)
    );

    // Fill level after this cycle; sum[3:0] is 0 on an exact fill and 2 after a straddle.
    always_comb begin
        bytes_n = bytes_used;
        if (accept) begin
            bytes_n = sum[3:0];
        end
        if (flush_commit) begin
            bytes_n = 4'd0;
        end
    end

    // Line storage and pointers; fill and drain never address the same line in one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines[i] <= '0;
            end
            fill_ptr   <= '0;
            drain_ptr  <= '0;
            bytes_used <= '0;
        end else begin
            if (accept) begin
                lines[fill_idx] <= merged_line;
                if (spill_vld) begin
                    lines[fill_nxt_idx] <= {{(LW-16){1'b0}}, spill_dat};
                end
            end
            if (drain_fire) begin
                lines[drain_idx] <= '0;
            end
            fill_ptr   <= fill_ptr + PW'(commit_w | flush_commit);
            drain_ptr  <= drain_ptr + PW'(drain_fire);
            bytes_used <= bytes_n;
        end
    end

    // Drain state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Drain next-state and push strobe: wait one cycle in IDLE, then push when downstream has room
    always_comb begin
        state_n   = state;
        fifo_we_o = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_n = PUSH;
                end
            end
            PUSH: begin
                fifo_we_o = ~fifo_full_i;
                if (~fifo_full_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign drain_fire   = fifo_we_o;
    assign fifo_wdata_o = lines[drain_idx];

endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer: byte-queue scoreboard checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: exercised by holding fifo_full_i.
module tb_fifo_packer;

    localparam int NL = 2;

    logic         clk;
    logic         rst_i;
    logic         we_i;
    logic         wsize_i;
    logic [31:0]  wdata_i;
    logic         full_o;
    logic         idle_o;
    logic         fifo_full_i;
    logic         fifo_we_o;
    logic [127:0] fifo_wdata_o;
    logic         flush_i;

    fifo_packer #(.NUM_LINES(NL), .LINE_BYTES(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .we_i         (we_i),
        .wsize_i      (wsize_i),
        .wdata_i      (wdata_i),
        .full_o       (full_o),
        .idle_o       (idle_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_we_o    (fifo_we_o),
        .fifo_wdata_o (fifo_wdata_o)
`ifdef FIFO_PACKER_FLUSH_EN
        ,
        .flush_i      (flush_i)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             total;
    int             bad;
    logic [7:0]     cur[$];
    logic [127:0]   q[$];
    logic [127:0]   push_log[$];
    bit             mfp;
    bit             mvalid;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard: accepted bytes accumulate in cur, every 16 become an expected line in q.
    task automatic compare_loop();
        int           cyc;
        int           pre;
        int           nb;
        bit           ef;
        bit           fl;
        logic [127:0] line;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                $display("FAIL timeout: got %0d cycles want under 20000", cyc);
                $fatal(1);
            end
            ef = (q.size() == NL) || (q.size() == NL - 1 && cur.size() == 14) || mfp;
            if (mvalid) begin
                chk("full_o", full_o, ef);
                chk("idle_o", idle_o, (q.size() == 0 && cur.size() == 0 && !mfp));
                if (fifo_we_o) begin
                    push_log.push_back(fifo_wdata_o);
                    if (fifo_full_i) chk("push_while_full", fifo_we_o, 1'b0);
                    if (q.size() == 0) chk("unexpected_push", fifo_we_o, 1'b0);
                    else chk("push_data", fifo_wdata_o, q[0]);
                end
            end
`ifdef FIFO_PACKER_FLUSH_EN
            fl = flush_i;
`else
            fl = 1'b0;
`endif
            if (rst_i) begin
                cur.delete();
                q.delete();
                mfp    = 1'b0;
                mvalid = 1'b1;
            end else if (mvalid) begin
                pre = q.size();
                if (fifo_we_o && q.size() > 0) void'(q.pop_front());
                if (we_i && !ef) begin
                    nb = wsize_i ? 4 : 2;
                    for (int b = 0; b < nb; b++) begin
                        cur.push_back(wdata_i[8*b +: 8]);
                        if (cur.size() == 16) begin
                            line = '0;
                            foreach (cur[i]) line[8*i +: 8] = cur[i];
                            q.push_back(line);
                            cur.delete();
                        end
                    end
                end
                if (mfp && pre < NL) begin
                    line = '0;
                    foreach (cur[i]) line[8*i +: 8] = cur[i];
                    q.push_back(line);
                    cur.delete();
                    mfp = 1'b0;
                end
                if (fl && cur.size() != 0) mfp = 1'b1;
            end
        end
    endtask

    task automatic do_write(input logic sz, input logic [31:0] d);
        logic was_full;
        bit   ok;
        ok      = 1'b0;
        wsize_i = sz;
        wdata_i = d;
        we_i    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            was_full = full_o;
            @(posedge clk);
            #1;
            if (!was_full) begin
                ok = 1'b1;
                break;
            end
        end
        we_i = 1'b0;
        if (!ok) chk("write_accept", 1'b0, 1'b1);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (idle_o) break;
            @(posedge clk);
            #1;
        end
        chk(nm, idle_o, 1'b1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        total       = 0;
        bad         = 0;
        mfp         = 1'b0;
        mvalid      = 1'b0;
        rst_i       = 1'b1;
        we_i        = 1'b0;
        wsize_i     = 1'b0;
        wdata_i     = '0;
        fifo_full_i = 1'b0;
        flush_i     = 1'b0;
        fork
            compare_loop();
        join_none
        cycles(2);
        rst_i = 1'b0;
        chk("rst_idle", idle_o, 1'b1);
        chk("rst_full", full_o, 1'b0);
        chk("rst_we", fifo_we_o, 1'b0);

        // 8x 32-bit incrementing bytes, with commit-to-push latency pinned
        base = push_log.size();
        for (int k = 0; k < 8; k++) begin
            do_write(1'b1, 32'h03020100 + 32'(k) * 32'h04040404);
            if (k == 3) chk("lat_n1_no_push", fifo_we_o, 1'b0);
            if (k == 4) chk("lat_n2_push", fifo_we_o, 1'b1);
        end
        wait_idle("t1_idle");
        chk("t1_cnt", 128'(push_log.size()), 128'(base + 2));
        chk("t1_line0", push_log[base],     128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("t1_line1", push_log[base + 1], 128'h1F1E1D1C_1B1A1918_17161514_13121110);

        // 7x 16-bit then a straddling 32-bit write
        base = push_log.size();
        for (int k = 0; k < 7; k++) do_write(1'b0, {16'h0, 8'(2*k+1), 8'(2*k)});
        do_write(1'b1, 32'hBBBBAAAA);
        chk("t2_pending_not_idle", idle_o, 1'b0);
        for (int k = 0; k < 7; k++) do_write(1'b0, 32'h00002222);
        wait_idle("t2_idle");
        chk("t2_cnt", 128'(push_log.size()), 128'(base + 2));
        chk("t2_line0", push_log[base],     128'hAAAA0D0C_0B0A0908_07060504_03020100);
        chk("t2_line1", push_log[base + 1], 128'h22222222_22222222_22222222_2222BBBB);

        // Downstream full: two lines buffer, then writes blocked, then drain in order
        base = push_log.size();
        fifo_full_i = 1'b1;
        for (int k = 0; k < 8; k++) do_write(1'b1, 32'h23222120 + 32'(k) * 32'h04040404);
        chk("t3_full", full_o, 1'b1);
        we_i = 1'b1; wsize_i = 1'b1; wdata_i = 32'hDEADBEEF;
        cycles(6);
        we_i = 1'b0;
        chk("t3_no_push", 128'(push_log.size()), 128'(base));
        fifo_full_i = 1'b0;
        wait_idle("t3_idle");
        chk("t3_cnt", 128'(push_log.size()), 128'(base + 2));
        chk("t3_line0", push_log[base],     128'h2F2E2D2C_2B2A2928_27262524_23222120);
        chk("t3_line1", push_log[base + 1], 128'h3F3E3D3C_3B3A3938_37363534_33323130);

        // One committed line plus 14 bytes: full even for a 16-bit write
        base = push_log.size();
        fifo_full_i = 1'b1;
        for (int k = 0; k < 4; k++) do_write(1'b1, 32'h44444444 + 32'(k));
        for (int k = 0; k < 7; k++) do_write(1'b0, 32'h00005500 + 32'(k));
        we_i = 1'b1; wsize_i = 1'b0; wdata_i = 32'h0000FFFF;
        for (int k = 0; k < 4; k++) begin
            chk("t4_full_14", full_o, 1'b1);
            cycles(1);
        end
        we_i = 1'b0;
        fifo_full_i = 1'b0;
        for (int i = 0; i < 50 && full_o; i++) cycles(1);
        chk("t4_unblocked", full_o, 1'b0);
        do_write(1'b0, 32'h00007777);
        wait_idle("t4_idle");
        chk("t4_cnt", 128'(push_log.size()), 128'(base + 2));
        chk("t4_line1", push_log[base + 1], 128'h77775506_55055504_55035502_55015500);

`ifdef FIFO_PACKER_FLUSH_EN
        // Flush a 6-byte partial line
        base = push_log.size();
        do_write(1'b0, 32'h00001111);
        do_write(1'b0, 32'h00002222);
        do_write(1'b0, 32'h00003333);
        flush_i = 1'b1;
        cycles(1);
        flush_i = 1'b0;
        chk("t5_flush_pend_full", full_o, 1'b1);
        wait_idle("t5_idle");
        chk("t5_cnt", 128'(push_log.size()), 128'(base + 1));
        chk("t5_line", push_log[base], 128'h00000000_00000000_00003333_22221111);
        flush_i = 1'b1;
        cycles(1);
        flush_i = 1'b0;
        chk("t5_noop_idle", idle_o, 1'b1);
`endif

        // Reset with a committed line and a partial line buffered
        base = push_log.size();
        fifo_full_i = 1'b1;
        for (int k = 0; k < 4; k++) do_write(1'b1, 32'h66666666);
        do_write(1'b0, 32'h00009999);
        chk("t6_not_idle", idle_o, 1'b0);
        rst_i = 1'b1;
        cycles(1);
        rst_i = 1'b0;
        fifo_full_i = 1'b0;
        chk("t6_idle", idle_o, 1'b1);
        chk("t6_full", full_o, 1'b0);
        chk("t6_we", fifo_we_o, 1'b0);
        cycles(10);
        chk("t6_no_push", 128'(push_log.size()), 128'(base));
        chk("t6_idle_late", idle_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
